// File: rtl/bitmap_decomp_pkg.sv
// Shared constants, state type and bitmap helpers for the
// bitmap-compressed payload sequencer.
package bitmap_decomp_pkg;

    localparam int NUM_ENTRIES = 8;
    localparam int CODE_W      = 2;
    localparam int LEN_W       = 6;
    localparam int TOT_W       = 9;
    localparam int IDX_W       = 3;
    localparam int BMP_W       = NUM_ENTRIES * CODE_W;

    localparam logic [LEN_W-1:0] SZ_ZERO = 6'd0;
    localparam logic [LEN_W-1:0] SZ_HALF = 6'd16;
    localparam logic [LEN_W-1:0] SZ_FULL = 6'd32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic [LEN_W-1:0] code_len(input logic [CODE_W-1:0] c);
        logic [LEN_W-1:0] l;
        l = SZ_ZERO;
        if (c == 2'b10) l = SZ_HALF;
        if (c == 2'b11) l = SZ_FULL;
        return l;
    endfunction

    // Codes 00/01 both mean zero length, so the upper bit alone marks data.
    function automatic logic [NUM_ENTRIES-1:0] nz_mask(input logic [BMP_W-1:0] bm);
        logic [NUM_ENTRIES-1:0] m;
        for (int i = 0; i < NUM_ENTRIES; i++) m[i] = bm[2*i+1];
        return m;
    endfunction

    function automatic logic [IDX_W-1:0] first_at(input logic [NUM_ENTRIES-1:0] m,
                                                  input logic [IDX_W:0] from);
        logic [IDX_W-1:0] r;
        r = '1;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (m[i] && (i >= int'(from))) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] last_idx(input logic [NUM_ENTRIES-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (m[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/bitmap_decomp_ctrl_offset.sv
// Combinational decode of a latched bitmap into per-entry lengths,
// prefix-sum start offsets, block total and nonzero mask.
module bitmap_offset_calc
    import bitmap_decomp_pkg::*;
(
    input  logic [BMP_W-1:0]                    bitmap,
    output logic [NUM_ENTRIES-1:0][LEN_W-1:0]   len,
    output logic [NUM_ENTRIES-1:0][TOT_W-1:0]   start,
    output logic [TOT_W-1:0]                    total,
    output logic [NUM_ENTRIES-1:0]              nz
);

    logic [TOT_W-1:0] acc;

    always_comb begin
        acc   = '0;
        len   = '0;
        start = '0;
        nz    = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            len[i]   = code_len(bitmap[2*i +: CODE_W]);
            start[i] = acc;
            nz[i]    = (len[i] != SZ_ZERO);
            acc      = acc + TOT_W'(len[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/bitmap_decomp_ctrl.sv
// Per-block sequencer: accepts one bitmap header, issues one extract
// command per entry, then pulses blk_done with the block length.
module bitmap_decomp_ctrl
    import bitmap_decomp_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hdr_valid,
    output logic              hdr_ready,
    input  logic [BMP_W-1:0]  hdr_bitmap,
    input  logic [ADDR_W-1:0] hdr_base,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [IDX_W-1:0]  cmd_idx,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_zero,
    output logic              cmd_last,
    output logic              blk_done,
    output logic [TOT_W-1:0]  blk_len
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BMP_W-1:0]    bm_q, bm_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                hdr_ready_q, hdr_ready_d;
    logic [TOT_W-1:0]    blk_len_q, blk_len_d;

    logic [NUM_ENTRIES-1:0][LEN_W-1:0] ent_len;
    logic [NUM_ENTRIES-1:0][TOT_W-1:0] ent_start;
    logic [TOT_W-1:0]                  ent_total;
    logic [NUM_ENTRIES-1:0]            ent_nz;

    logic [NUM_ENTRIES-1:0] in_nz;
    logic                   hdr_fire;
    logic                   issuing;
    logic                   cur_last;
    logic [LEN_W-1:0]       cur_len;
    logic [ADDR_W-1:0]      cur_addr;

    bitmap_offset_calc u_offs (
        .bitmap (bm_q),
        .len    (ent_len),
        .start  (ent_start),
        .total  (ent_total),
        .nz     (ent_nz)
    );

    always_comb begin
        in_nz    = nz_mask(hdr_bitmap);
        hdr_fire = hdr_valid & hdr_ready_q & (state_q == IDLE);
        issuing  = (state_q == ISSUE);
        cur_len  = ent_len[idx_q];
        cur_addr = base_q + ADDR_W'(ent_start[idx_q]);
        if (SKIP_ZERO) cur_last = (idx_q == last_idx(ent_nz));
        else           cur_last = (idx_q == IDX_W'(NUM_ENTRIES - 1));
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bm_d      = bm_q;
        base_d    = base_q;
        blk_len_d = blk_len_q;
        unique case (state_q)
            IDLE: begin
                if (hdr_fire) begin
                    bm_d   = hdr_bitmap;
                    base_d = hdr_base;
                    if (SKIP_ZERO && (in_nz == '0)) begin
                        state_d   = DONE;
                        blk_len_d = '0;
                    end else begin
                        state_d = ISSUE;
                        idx_d   = SKIP_ZERO ? first_at(in_nz, '0) : '0;
                    end
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    if (cur_last) begin
                        state_d   = DONE;
                        blk_len_d = ent_total;
                    end else if (SKIP_ZERO) begin
                        idx_d = first_at(ent_nz, {1'b0, idx_q} + 1'b1);
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        hdr_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            bm_q        <= '0;
            base_q      <= '0;
            hdr_ready_q <= 1'b0;
            blk_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bm_q        <= bm_d;
            base_q      <= base_d;
            hdr_ready_q <= hdr_ready_d;
            blk_len_q   <= blk_len_d;
        end
    end

    // Command fields are forced to zero outside ISSUE so idle outputs stay clean.
    always_comb begin
        hdr_ready = hdr_ready_q;
        cmd_valid = issuing;
        cmd_idx   = issuing ? idx_q : '0;
        cmd_addr  = issuing ? cur_addr : '0;
        cmd_len   = issuing ? cur_len : '0;
        cmd_zero  = issuing & (cur_len == SZ_ZERO);
        cmd_last  = issuing & cur_last;
        blk_done  = (state_q == DONE);
        blk_len   = blk_len_q;
    end

endmodule

// File: tb/tb_bitmap_decomp_ctrl.sv
// Randomised and directed checks of bitmap_decomp_ctrl against a
// queue-based reference model, for SKIP_ZERO = 0 and 1.
module tb_bitmap_decomp_ctrl;

    typedef struct {
        int idx;
        int addr;
        int len;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hv[2];
    logic [15:0] hbm[2];
    logic [15:0] hbs[2];
    logic        crdy[2];
    logic        hr[2];
    logic        cv[2];
    logic [2:0]  ci[2];
    logic [15:0] ca[2];
    logic [5:0]  clen[2];
    logic        cz[2];
    logic        cl[2];
    logic        bd[2];
    logic [8:0]  bl[2];

    int   total = 0;
    int   bad   = 0;
    cmd_t exp_q[$];
    int   exp_tot;

    always #5 clk = ~clk;

    bitmap_decomp_ctrl #(.ADDR_W(16), .SKIP_ZERO(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .hdr_valid(hv[0]), .hdr_ready(hr[0]),
        .hdr_bitmap(hbm[0]), .hdr_base(hbs[0]),
        .cmd_valid(cv[0]), .cmd_ready(crdy[0]),
        .cmd_idx(ci[0]), .cmd_addr(ca[0]), .cmd_len(clen[0]),
        .cmd_zero(cz[0]), .cmd_last(cl[0]),
        .blk_done(bd[0]), .blk_len(bl[0])
    );

    bitmap_decomp_ctrl #(.ADDR_W(16), .SKIP_ZERO(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .hdr_valid(hv[1]), .hdr_ready(hr[1]),
        .hdr_bitmap(hbm[1]), .hdr_base(hbs[1]),
        .cmd_valid(cv[1]), .cmd_ready(crdy[1]),
        .cmd_idx(ci[1]), .cmd_addr(ca[1]), .cmd_len(clen[1]),
        .cmd_zero(cz[1]), .cmd_last(cl[1]),
        .blk_done(bd[1]), .blk_len(bl[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input int s, input string tag);
        chk({tag, "_cv"}, 32'(cv[s]), 0);
        chk({tag, "_ci"}, 32'(ci[s]), 0);
        chk({tag, "_ca"}, 32'(ca[s]), 0);
        chk({tag, "_clen"}, 32'(clen[s]), 0);
        chk({tag, "_cz"}, 32'(cz[s]), 0);
        chk({tag, "_cl"}, 32'(cl[s]), 0);
        chk({tag, "_bd"}, 32'(bd[s]), 0);
        chk({tag, "_bl"}, 32'(bl[s]), 0);
        chk({tag, "_hr"}, 32'(hr[s]), 0);
    endtask

    // Expected command list straight from the size-code rules.
    task automatic build(input logic [15:0] bm, input logic [15:0] base, input bit skip);
        int start;
        int code;
        int len;
        cmd_t c;
        exp_q.delete();
        start = 0;
        for (int i = 0; i < 8; i++) begin
            code = (int'(bm) >> (2 * i)) & 3;
            len  = (code == 3) ? 32 : ((code == 2) ? 16 : 0);
            if (!skip || len != 0) begin
                c.idx  = i;
                c.addr = (int'(base) + start) % 65536;
                c.len  = len;
                exp_q.push_back(c);
            end
            start += len;
        end
        exp_tot = start;
    endtask

    task automatic run_block(input int s, input logic [15:0] bm, input logic [15:0] base,
                             input bit rnd, input int abort_after);
        int   hs;
        int   cyc;
        bit   done;
        cmd_t e;
        build(bm, base, s == 1);
        @(negedge clk);
        cyc = 0;
        while (hr[s] !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("hdr_ready_wait", 32'(hr[s]), 1);
        hv[s]  = 1'b1;
        hbm[s] = bm;
        hbs[s] = base;
        @(negedge clk);
        hv[s] = 1'b0;
        hs    = 0;
        done  = 1'b0;
        for (cyc = 0; cyc < 300 && !done; cyc++) begin
            if (abort_after >= 0 && hs == abort_after) return;
            chk("busy_hdr_ready", 32'(hr[s]), 0);
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                chk("cmd_valid", 32'(cv[s]), 1);
                chk("cmd_idx", 32'(ci[s]), 32'(e.idx));
                chk("cmd_addr", 32'(ca[s]), 32'(e.addr));
                chk("cmd_len", 32'(clen[s]), 32'(e.len));
                chk("cmd_zero", 32'(cz[s]), 32'(e.len == 0));
                chk("cmd_last", 32'(cl[s]), 32'(exp_q.size() == 1));
                chk("early_done", 32'(bd[s]), 0);
                crdy[s] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (crdy[s]) begin
                    void'(exp_q.pop_front());
                    hs++;
                end
                hbm[s] = 16'($urandom);
                hbs[s] = 16'($urandom);
                @(negedge clk);
            end else begin
                chk("blk_done", 32'(bd[s]), 1);
                chk("blk_len", 32'(bl[s]), 32'(exp_tot));
                chk("done_cmd_valid", 32'(cv[s]), 0);
                done = 1'b1;
            end
        end
        if (!done) chk("block_timeout", 0, 1);
        crdy[s] = 1'b0;
        @(negedge clk);
        chk("post_done_pulse", 32'(bd[s]), 0);
        chk("post_hdr_ready", 32'(hr[s]), 1);
        chk("blk_len_hold", 32'(bl[s]), 32'(exp_tot));
    endtask

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            hv[s] = 1'b0; hbm[s] = '0; hbs[s] = '0; crdy[s] = 1'b0;
        end
        #1;
        chk_idle_outs(0, "rst0");
        chk_idle_outs(1, "rst1");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_hr_low", 32'(hr[0]), 0);
        @(negedge clk);
        chk("rel_hr0", 32'(hr[0]), 1);
        chk("rel_hr1", 32'(hr[1]), 1);

        run_block(0, 16'hFFFF, 16'h0100, 1'b0, -1);
        run_block(0, 16'h00E6, 16'h0040, 1'b0, -1);
        run_block(1, 16'h00E6, 16'h0040, 1'b0, -1);
        run_block(1, 16'h5555, 16'h1234, 1'b0, -1);
        run_block(0, 16'hFFFF, 16'hFFF0, 1'b0, -1);
        run_block(1, 16'hFFFF, 16'hFFF0, 1'b1, -1);
        for (int k = 0; k < 8; k++) begin
            run_block(k % 2, 16'($urandom), 16'($urandom), 1'b1, -1);
        end

        run_block(0, 16'hFFFF, 16'h0200, 1'b0, 3);
        rst_n = 1'b0;
        #1;
        chk_idle_outs(0, "midrst");
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(bd[0]), 0);
            chk("midrst_no_cmd", 32'(cv[0]), 0);
        end
        rst_n = 1'b1;
        #1;
        chk("midrst_hr_low", 32'(hr[0]), 0);
        @(negedge clk);
        chk("midrst_hr_back", 32'(hr[0]), 1);
        chk("midrst_still_no_done", 32'(bd[0]), 0);
        run_block(0, 16'h00E6, 16'h0040, 1'b1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
